// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle core.
// Ports: clk, rst (async, active-low); start/step/clear commands;
//   halt_req, instr_halt, bp_en/bp_addr, max_instr stop sources;
//   pc from core; core_rst/core_en to core; busy/done/halt_cause/
//   instr_count status.
module cpu_run_ctrl #(
  parameter int PC_W       = 16,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic             clear,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [CNT_W-1:0] max_instr,
  input  logic [PC_W-1:0]  pc,
  input  logic             instr_halt,
  output logic             core_rst,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALTED
  } state_t;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_REQ  = 3'd1;
  localparam logic [2:0] C_INSTR = 3'd2;
  localparam logic [2:0] C_BP   = 3'd3;
  localparam logic [2:0] C_LIM  = 3'd4;
  localparam logic [2:0] C_STEP = 3'd5;

  localparam int RC_W =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST =
    RC_W'(RST_CYCLES - 1);

  state_t           state;
  logic [RC_W-1:0]  rcnt;
  logic             bp_skip;
  logic             core_rst_q;
  logic             bp_hit;
  logic             stop;
  logic             step_stop;
  logic             lim_hit;
  logic [CNT_W:0]   cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;

  // bp_skip masks the breakpoint we just halted on so a resume
  // can retire the instruction sitting at bp_addr.
  assign bp_hit    = bp_en && (pc == bp_addr) && !bp_skip;
  assign stop      = halt_req | instr_halt | bp_hit;
  assign step_stop = halt_req | instr_halt;

  // One extra bit so a saturated counter never matches the limit.
  assign cnt_nxt = {1'b0, instr_count} + (CNT_W+1)'(1);
  assign cnt_inc = cnt_nxt[CNT_W] ? instr_count
                                  : cnt_nxt[CNT_W-1:0];
  assign lim_hit = (max_instr != '0) &&
                   (cnt_nxt == {1'b0, max_instr});

  always_comb begin
    core_en = 1'b0;
    unique case (state)
      S_RUN:   core_en = !stop;
      S_STEP:  core_en = !step_stop;
      default: core_en = 1'b0;
    endcase
  end

  assign core_rst = core_rst_q;
  assign busy     = (state == S_RESET) ||
                    (state == S_RUN) ||
                    (state == S_STEP);
  assign done     = (state == S_HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_RESET;
      rcnt        <= '0;
      instr_count <= '0;
      halt_cause  <= C_NONE;
      bp_skip     <= 1'b0;
      core_rst_q  <= 1'b1;
    end else begin
      if (core_en) begin
        instr_count <= cnt_inc;
        bp_skip     <= 1'b0;
      end
      unique case (state)
        S_RESET: begin
          if (rcnt == RC_LAST) begin
            state      <= S_IDLE;
            core_rst_q <= 1'b0;
          end else begin
            rcnt <= rcnt + RC_W'(1);
          end
        end
        S_IDLE, S_HALTED: begin
          if (clear) begin
            state       <= S_RESET;
            rcnt        <= '0;
            core_rst_q  <= 1'b1;
            instr_count <= '0;
            halt_cause  <= C_NONE;
            bp_skip     <= 1'b0;
          end else if (start || step) begin
            state <= start ? S_RUN : S_STEP;
            if (state == S_HALTED && halt_cause == C_BP)
              bp_skip <= 1'b1;
          end
        end
        S_RUN: begin
          if (stop) begin
            state      <= S_HALTED;
            halt_cause <= halt_req   ? C_REQ :
                          instr_halt ? C_INSTR : C_BP;
          end else if (lim_hit) begin
            state      <= S_HALTED;
            halt_cause <= C_LIM;
          end
        end
        S_STEP: begin
          state      <= S_HALTED;
          halt_cause <= halt_req   ? C_REQ :
                        instr_halt ? C_INSTR : C_STEP;
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with a toy core whose
// PC advances by 4 per retired instruction.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic        halt_req = 1'b0;
  logic        clear = 1'b0;
  logic        bp_en = 1'b0;
  logic [15:0] bp_addr = '0;
  logic [15:0] max_instr = '0;
  logic [15:0] pc;
  logic        instr_halt;
  logic        core_rst;
  logic        core_en;
  logic        busy;
  logic        done;
  logic [2:0]  halt_cause;
  logic [15:0] instr_count;

  logic        hen = 1'b0;
  logic [15:0] halt_pc = '0;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_run_ctrl #(.PC_W(16), .CNT_W(16), .RST_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step),
    .halt_req(halt_req), .clear(clear), .bp_en(bp_en),
    .bp_addr(bp_addr), .max_instr(max_instr), .pc(pc),
    .instr_halt(instr_halt), .core_rst(core_rst),
    .core_en(core_en), .busy(busy), .done(done),
    .halt_cause(halt_cause), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_rst) pc <= '0;
    else if (core_en) pc <= pc + 16'd4;
  end

  assign instr_halt = hen && (pc == halt_pc);

  task automatic cmd_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic cmd_step();
    @(negedge clk) step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
  endtask

  // Runs until done; halt_req goes high from RUN cycle treq on.
  task automatic run_count(input int treq, input int budget,
                           output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      halt_req = (c >= treq);
      #1;
      if (core_en) n++;
      @(posedge clk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    halt_req = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL run_timeout: got done=%0d want 1", done);
    end
  endtask

  task automatic do_clear();
    @(negedge clk) clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    n_cmp++;
    if (core_rst !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_rst1: got %0d want 1", core_rst);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (core_rst !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_rst2: got %0d want 1", core_rst);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({core_rst, busy, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL clr_idle: got rst/busy/done=%b want 000",
               {core_rst, busy, done});
    end
    n_cmp++;
    if (instr_count !== 16'd0 || halt_cause !== 3'd0) begin
      n_bad++;
      $display("FAIL clr_status: got cnt=%0d cause=%0d want 0 0",
               instr_count, halt_cause);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({core_rst, core_en, busy, done} !== 4'b1010 ||
        instr_count !== 16'd0 || halt_cause !== 3'd0) begin
      n_bad++;
      $display("FAIL rst_hold: got rst/en/busy/done=%b cnt=%0d cause=%0d want 1010 0 0",
               {core_rst, core_en, busy, done}, instr_count, halt_cause);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({core_rst, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL rst_cyc1: got rst/busy=%b want 11",
               {core_rst, busy});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({core_rst, core_en, busy, done} !== 4'b0000 ||
        instr_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_idle: got rst/en/busy/done=%b cnt=%0d want 0000 0",
               {core_rst, core_en, busy, done}, instr_count);
    end
  endtask

  task automatic test_count_limit();
    int n;
    bit ok;
    max_instr = 16'd15;
    cmd_start();
    run_count(1000, 100, n, ok);
    n_cmp++;
    if (n != 15 || instr_count !== 16'd15 ||
        halt_cause !== 3'd4) begin
      n_bad++;
      $display("FAIL limit: got en=%0d cnt=%0d cause=%0d want 15 15 4",
               n, instr_count, halt_cause);
    end
  endtask

  task automatic test_breakpoint();
    int n;
    bit ok;
    do_clear();
    max_instr = '0;
    bp_en = 1'b1;
    bp_addr = 16'h000C;
    cmd_start();
    run_count(1000, 100, n, ok);
    n_cmp++;
    if (n != 3 || instr_count !== 16'd3 ||
        halt_cause !== 3'd3 || pc !== 16'h000C) begin
      n_bad++;
      $display("FAIL bp_hit: got en=%0d cnt=%0d cause=%0d pc=%h want 3 3 3 000c",
               n, instr_count, halt_cause, pc);
    end
    cmd_start();
    #1;
    n_cmp++;
    if (core_en !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_skip: got core_en=%0d want 1", core_en);
    end
    run_count(2, 100, n, ok);
    n_cmp++;
    if (n != 2 || instr_count !== 16'd5 ||
        halt_cause !== 3'd1) begin
      n_bad++;
      $display("FAIL bp_resume: got en=%0d cnt=%0d cause=%0d want 2 5 1",
               n, instr_count, halt_cause);
    end
  endtask

  task automatic test_step();
    logic [15:0] want;
    for (int i = 0; i < 3; i++) begin
      want = instr_count + 16'd1;
      cmd_step();
      #1;
      n_cmp++;
      if (core_en !== 1'b1) begin
        n_bad++;
        $display("FAIL step_en%0d: got %0d want 1", i, core_en);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b1 || halt_cause !== 3'd5 ||
          instr_count !== want) begin
        n_bad++;
        $display("FAIL step%0d: got done=%0d cause=%0d cnt=%0d want 1 5 %0d",
                 i, done, halt_cause, instr_count, want);
      end
    end
  endtask

  task automatic test_priority();
    do_clear();
    bp_en = 1'b1;
    bp_addr = 16'h0000;
    hen = 1'b1;
    halt_pc = 16'h0000;
    max_instr = '0;
    halt_req = 1'b1;
    cmd_start();
    #1;
    n_cmp++;
    if (core_en !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_en: got %0d want 0", core_en);
    end
    @(posedge clk); #1;
    halt_req = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || halt_cause !== 3'd1 ||
        instr_count !== 16'd0) begin
      n_bad++;
      $display("FAIL prio_req: got done=%0d cause=%0d cnt=%0d want 1 1 0",
               done, halt_cause, instr_count);
    end
    cmd_start();
    @(posedge clk); #1;
    n_cmp++;
    if (halt_cause !== 3'd2 || instr_count !== 16'd0) begin
      n_bad++;
      $display("FAIL prio_instr: got cause=%0d cnt=%0d want 2 0",
               halt_cause, instr_count);
    end
    do_clear();
    hen = 1'b0;
    bp_en = 1'b0;
  endtask

  task automatic test_async_rst();
    cmd_start();
    @(posedge clk);
    @(posedge clk); #2;
    n_cmp++;
    if (core_en !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_pre: got core_en=%0d want 1", core_en);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({core_en, core_rst, busy, done} !== 4'b0110 ||
        instr_count !== 16'd0) begin
      n_bad++;
      $display("FAIL arst: got en/rst/busy/done=%b cnt=%0d want 0110 0",
               {core_en, core_rst, busy, done}, instr_count);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    n_cmp++;
    if ({core_rst, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL arst_rel: got rst/busy=%b want 00",
               {core_rst, busy});
    end
  endtask

  task automatic test_random_runs();
    int n, k, treq, mx, cause, want_n;
    bit ok;
    logic [15:0] hpc, bpa;
    bit ben;
    for (int it = 0; it < 20; it++) begin
      do_clear();
      hpc = 16'(4 * $urandom_range(0, 40));
      bpa = 16'(4 * $urandom_range(0, 40));
      ben = 1'($urandom_range(0, 1));
      mx = ($urandom_range(0, 3) == 0) ? 0
                                       : $urandom_range(1, 45);
      treq = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 50)
                                         : 1000;
      // Program model: instruction k lives at pc 4*k.
      k = 0;
      cause = 0;
      for (int c = 0; c < 200; c++) begin
        if (c >= treq) begin cause = 1; break; end
        if (4 * k == int'(hpc)) begin cause = 2; break; end
        if (ben && 4 * k == int'(bpa)) begin cause = 3; break; end
        k++;
        if (mx != 0 && k == mx) begin cause = 4; break; end
      end
      want_n = k;
      hen = 1'b1;
      halt_pc = hpc;
      bp_en = ben;
      bp_addr = bpa;
      max_instr = 16'(mx);
      cmd_start();
      run_count(treq, 100, n, ok);
      n_cmp++;
      if (n != want_n || int'(instr_count) != want_n ||
          int'(halt_cause) != cause) begin
        n_bad++;
        $display("FAIL rand%0d: got en=%0d cnt=%0d cause=%0d want %0d %0d %0d",
                 it, n, instr_count, halt_cause, want_n, want_n, cause);
      end
    end
    hen = 1'b0;
    bp_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_limit();
    test_breakpoint();
    test_step();
    test_priority();
    test_async_rst();
    test_random_runs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
